bcd_to_binary_converter: RTL and testbench
==========================================

Name: bcd_to_binary_converter

Overview:
Iterative packed-BCD to unsigned binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from each BCD nibble >= 8. Accepts DIGITS packed BCD digits via a start/done handshake. Sits between keypad/BCD entry logic and binary arithmetic in the counter/display datapath, as the inverse of the binary-to-BCD stage feeding the display driver.

Parameters:
DIGITS, 4, number of packed BCD digits on bcd_in
BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (14 for 4 digits)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request conversion; sampled only in IDLE
bcd_in  input  4*DIGITS  packed BCD operand, digit 0 in [3:0]; sampled with accepted start
binary_out  output  BIN_W  converted value; held until next done
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse: result/error valid
error  output  1  operand had a nibble > 9; valid with done, held until next accepted start

Behaviour:
- All outputs and internal state are registers. rst low clears them immediately: binary_out=0, busy=0, done=0, error=0, state=IDLE, bit counter=0, shift register=0.
- States: IDLE, SHIFT.
- IDLE: done defaults to 0. On a rising edge with start=1, check every nibble of bcd_in.
  - Any nibble > 9: stay in IDLE. Set done=1, error=1, binary_out=0 for one cycle. Latency is 1 edge.
  - All valid: load shift register {bcd_in, BIN_W'b0} (width 4*DIGITS+BIN_W). Clear error, set busy=1, clear the counter, go to SHIFT.
- SHIFT, one iteration per edge:
  - Logical right shift of the whole register by 1.
  - Then for each BCD nibble of the shifted upper field: if >= 8, subtract 3 (4-bit, no borrow across nibbles).
  - Increment the counter.
- On the edge completing iteration BIN_W:
  - binary_out = low BIN_W bits of the post-shift value.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+BIN_W (14 for the defaults). busy is high for BIN_W cycles.
- start while busy: ignored; bcd_in changes during SHIFT have no effect.
- start high in the cycle where done=1 (state is IDLE): accepted. Back-to-back throughput is 1 conversion per BIN_W+1 cycles.
- start held high continuously: a new conversion starts at each return to IDLE.
- Reset mid-conversion: abort immediately. No done pulse, binary_out=0.
- Full-scale input (all 9s) must convert exactly. No overflow is possible for legal BIN_W.
- error is never set for valid operands. The done/error pair is the only completion indication.

Test Plan:
1. Reset low for 3 cycles, release; start=1 with bcd_in=16'h9999 -> busy high 14 cycles, then done=1 for one cycle with binary_out=14'd9999 (0x270F), error=0.
2. bcd_in=16'h0000 -> done after 14 cycles, binary_out=0. bcd_in=16'h1234 -> binary_out=14'd1234 (0x4D2). bcd_in=16'h0808 -> binary_out=14'd808.
3. bcd_in=16'h12A4 (invalid nibble) -> done=1 and error=1 one cycle after start, binary_out=0, busy never asserts. A following valid start clears error.
4. Start 16'h0042, then pulse start with 16'h0777 at cycle 5 of busy -> second start ignored. Result is 42 at cycle 14 with a single done pulse.
5. Start held high continuously with bcd_in=16'h0500 -> done pulses every 15 cycles, each binary_out=500.
6. Start 16'h9999, assert rst low at cycle 7 -> busy=0 and binary_out=0 immediately. No done pulse after release. A new start of 16'h0001 yields 1.

Source files
------------

// File: rtl/bcd_to_binary_converter.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_converter
//
// Purpose:
//   Iterative packed-BCD to unsigned binary converter ("reverse double-dabble").
//   The operand is loaded into the upper field of a shift register and shifted
//   right one bit per cycle. After each shift, any BCD nibble that reads >= 8
//   has 3 subtracted from it. After BIN_W iterations the lower BIN_W bits hold
//   the binary value. The block is the inverse of the binary-to-BCD stage that
//   feeds the display driver. It sits between keypad/BCD entry logic and the
//   binary arithmetic in the counter/display datapath.
//
// Parameters:
//   DIGITS     number of packed BCD digits on bcd_in (default 4)
//   BIN_W      binary result width. It must satisfy 2^BIN_W > 10^DIGITS - 1
//              (default 14).
//
// Ports:
//   clk        in   1         system clock, rising edge
//   rst        in   1         asynchronous reset, active low
//   start      in   1         conversion request, sampled only while idle
//   bcd_in     in   4*DIGITS  packed BCD operand, digit 0 in [3:0]
//   binary_out out  BIN_W     converted value, held until the next done
//   busy       out  1         high while a conversion is in progress
//   done       out  1         one-cycle pulse: binary_out/error are valid
//   error      out  1         operand contained a nibble > 9. It is valid with
//                             done and held until the next accepted start.
// -----------------------------------------------------------------------------
module bcd_to_binary_converter #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      binary_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // The shift register holds the BCD field above the binary field.
    localparam int SR_W  = 4*DIGITS + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;

    logic [SR_W-1:0]    w_shifted;
    logic [SR_W-1:0]    w_sr_next;
    logic               w_bad_digit;
    logic               w_last_iter;

    // One iteration: a logical right shift of the whole register. Each BCD
    // nibble then gets its own 4-bit correction. A nibble that reads >= 8 just
    // received a bit worth 10/2 = 5 from the digit above. That bit was shifted
    // in with binary weight 8, so 3 is taken off. No borrow crosses into the
    // neighbouring nibble.
    assign w_shifted = r_sr >> 1;

    // NOTE: every variable an always_comb block writes gets a default
    // assignment first. Otherwise a path that skips the write infers a latch.
    always_comb begin
        w_sr_next = w_shifted;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
                w_sr_next[BIN_W + 4*i +: 4] = w_shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // The operand is rejected as a whole if any digit is outside 0..9.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // The counter is cleared on load. The edge that sees count BIN_W-1
    // completes iteration BIN_W.
    assign w_last_iter = (r_cnt == CNT_W'(BIN_W - 1));

    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then samples its pre-edge inputs, whatever the statement order.
    // NOTE: the shift register and counter are ordinary flops, not a memory
    // array. They are cleared by reset together with the rest of the state, so
    // an aborted conversion leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sr       <= '0;
            r_cnt      <= '0;
            binary_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless a branch below re-asserts it.
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_bad_digit) begin
                            // Reject immediately. The result is forced to 0
                            // and the state machine stays idle.
                            done       <= 1'b1;
                            error      <= 1'b1;
                            binary_out <= '0;
                        end else begin
                            r_sr    <= {bcd_in, {BIN_W{1'b0}}};
                            r_cnt   <= '0;
                            error   <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end

                S_SHIFT: begin
                    // start and bcd_in are ignored here. Only the loaded
                    // operand is used.
                    r_sr  <= w_sr_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last_iter) begin
                        binary_out <= w_sr_next[BIN_W-1:0];
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_converter
//
// Testbench for bcd_to_binary_converter with default parameters
// (DIGITS=4, BIN_W=14).
//
// Stimulus drives inputs on the falling edge. When a conversion is expected to
// complete, the stimulus pushes its hand-computed result onto a queue. A
// separate monitor samples on the falling edge. Whenever done is high, it pops
// the oldest entry and compares binary_out and error against it. Latency, busy
// duration, reset behaviour and ignored-start cases are checked directly by the
// stimulus process.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_converter;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    typedef struct {
        string            name;
        logic [BIN_W-1:0] bin;
        logic             err;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                start;
    logic [4*DIGITS-1:0] bcd_in;
    logic [BIN_W-1:0]    binary_out;
    logic                busy;
    logic                done;
    logic                error;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    int   push_cnt  = 0;

    bcd_to_binary_converter #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bcd_in     (bcd_in),
        .binary_out (binary_out),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_result(input string name, input logic [BIN_W-1:0] bin, input logic err);
        exp_t e;
        e.name = name;
        e.bin  = bin;
        e.err  = err;
        sb_q.push_back(e);
        push_cnt++;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_bin"}, 32'(binary_out), 32'(e.bin));
                check({e.name, "_err"}, 32'(error), 32'(e.err));
            end
        end
    end

    // Waits for done, counting falling edges from the current one. It returns
    // the number of edges until done is seen (1 = the next falling edge) and
    // how many of those edges had busy high. drop_start releases start at the
    // first falling edge.
    task automatic wait_done(input bit drop_start, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1 && drop_start) begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                lat = i;
                return;
            end
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Issues one single-cycle start and waits for its completion.
    task automatic run_conv(input string name, input logic [15:0] bcd,
                            input logic [BIN_W-1:0] exp_bin, input logic exp_err);
        int lat, bc;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = bcd;
        expect_result(name, exp_bin, exp_err);
        wait_done(1'b1, lat, bc);
        if (exp_err) begin
            check({name, "_latency"}, 32'(lat), 32'd1);
            check({name, "_busy_cycles"}, 32'(bc), 32'd0);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(BIN_W + 1));
            check({name, "_busy_cycles"}, 32'(bc), 32'(BIN_W));
        end
    endtask

    initial begin
        int lat, bc, d0;
        rst    = 1'b0;
        start  = 1'b0;
        bcd_in = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_binary_out", 32'(binary_out), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        rst = 1'b1;

        // Full scale and ordinary operands.
        run_conv("full_9999", 16'h9999, 14'd9999, 1'b0);
        run_conv("zero",      16'h0000, 14'd0,    1'b0);
        run_conv("v1234",     16'h1234, 14'd1234, 1'b0);
        run_conv("v0808",     16'h0808, 14'd808,  1'b0);
        run_conv("v1000",     16'h1000, 14'd1000, 1'b0);
        run_conv("v0099",     16'h0099, 14'd99,   1'b0);

        // Invalid digit: immediate done with error, no busy. A valid start
        // then clears error.
        run_conv("bad_12A4",  16'h12A4, 14'd0,    1'b1);
        @(negedge clk);
        check("error_held", 32'(error), 32'd1);
        run_conv("bad_F000",  16'hF000, 14'd0,    1'b1);
        run_conv("after_bad", 16'h0007, 14'd7,    1'b0);

        // A start while busy is ignored.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0042;
        expect_result("busy_ignore", 14'd42, 1'b0);
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_pulse", 32'(busy), 32'd1);
        start  = 1'b1;
        bcd_in = 16'h0777;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'h0000;
        wait_done(1'b0, lat, bc);
        check("busy_ignore_latency", 32'(lat), 32'd9);
        @(posedge clk);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("busy_ignore_single_done", 32'(done_cnt), 32'(d0));

        // Start held high: back-to-back conversions every BIN_W+1 cycles.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0500;
        for (int j = 0; j < 3; j++) expect_result("held_0500", 14'd500, 1'b0);
        for (int j = 0; j < 3; j++) begin
            wait_done(1'b0, lat, bc);
            check("held_period", 32'(lat), 32'(BIN_W + 1));
        end
        start = 1'b0;
        @(posedge clk);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("held_stop", 32'(done_cnt), 32'(d0));

        // Reset in the middle of a conversion.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h9999;
        @(negedge clk);
        start  = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy",       32'(busy),       32'd0);
        check("abort_binary_out", 32'(binary_out), 32'd0);
        check("abort_done",       32'(done),       32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        run_conv("after_abort", 16'h0001, 14'd1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(push_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
